shift_add_mul: RTL

//  Iterative N-bit unsigned shift-and-add multiplier, 2N-bit product.

---
 rtl/shift_add_mul.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/shift_add_mul.sv
// shift_add_mul: iterative N-bit unsigned shift-and-add multiplier with a
// 2N-bit registered product and valid/ready handshakes on both sides.
// A ripple-carry adder (rca_add) forms one partial product per clock.
// Optional feature macro: SHORTCUT_ZERO_EN. When it is defined, a zero
// operand skips the CALC phase entirely.

// rca_add: N-bit ripple-carry adder built from a chain of full adders.
module rca_add #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] w_carry;

    assign w_carry[0] = cin;

    // One full adder per bit; carry ripples from bit 0 upward.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_fa
            assign sum[gi]       = a[gi] ^ b[gi] ^ w_carry[gi];
            assign w_carry[gi+1] = (a[gi] & b[gi]) | (w_carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = w_carry[N];

endmodule

module shift_add_mul #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_mcand;
    // Accumulator {hi, lo}. The carry position above hi is zero after every
    // right shift (the shifted-in bit is always 0), so it is not stored.
    logic [2*N-1:0]   r_acc;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;
    logic [2*N-1:0]   r_product;

    logic [N-1:0]     w_hi;
    logic [N-1:0]     w_lo;
    logic [N-1:0]     w_add_b;
    logic [N-1:0]     w_sum;
    logic             w_cout;
    logic [2*N-1:0]   w_acc_next;
    logic             w_accept;
    logic             w_last;

    assign w_hi = r_acc[2*N-1:N];
    assign w_lo = r_acc[N-1:0];

    // The multiplier LSB gates the multiplicand into the adder.
    assign w_add_b = w_lo[0] ? r_mcand : '0;

    rca_add #(
        .N(N)
    ) u_add (
        .a    (w_hi),
        .b    (w_add_b),
        .cin  (1'b0),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // {carry, cout, sum, lo} >> 1: cout lands in the hi MSB, sum[0] moves
    // into the lo MSB and the consumed multiplier bit falls off the bottom.
    assign w_acc_next = {w_cout, w_sum, w_lo[N-1:1]};

    assign w_last   = (r_cnt == CW'(N - 1));
    assign in_ready = (r_state == S_IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign product   = r_product;

    // Control FSM and datapath registers: accept, iterate N steps, hold result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_product   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_mcand <= a;
                        r_acc   <= {{N{1'b0}}, b};
                        r_cnt   <= '0;
`ifdef SHORTCUT_ZERO_EN
                        // A zero operand makes the product zero; skip the steps.
                        if ((a == '0) || (b == '0)) begin
                            r_product   <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end else begin
                            r_state <= S_CALC;
                        end
`else
                        r_state <= S_CALC;
`endif
                    end
                end

                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CW'(1);
                    if (w_last) begin
                        // The Nth step's result is the final product.
                        r_product   <= w_acc_next;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
